// File: rtl/lcd_sed1565.sv
// lcd_sed1565 -- responder model of an SED1565 LCD controller.
//
// The CPU (and the PRC frame copy) reach the controller through two bus
// registers: CMD_ADDR (command write / status read) and DATA_ADDR (display
// RAM data read/write). Display RAM is 9 pages x 132 columns; page 8 is the
// icon row. A second, independent RAM port serves the video scanout stage.
//
// Optional feature macro: LCD_RMW_EN
//   defined   -> 0xE0/0xEE read-modify-write mode (reads hold the column,
//                0xEE restores the column saved by 0xE0)
//   undefined -> 0xE0/0xEE are ignored and reads always advance the column
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   bus_write/read     one-cycle strobes (write wins when both are high)
//   bus_address_in     24-bit bus address
//   bus_data_in        write data
//   bus_data_out       read data, combinational from registers
//   scan_page/column   scanout page and logical column
//   scan_data          scanout byte, registered (one cycle after inputs)
//   start_line         display start line
//   contrast           contrast level
//   display_on         display enable
module lcd_sed1565 #(
  parameter logic [23:0] CMD_ADDR  = 24'h20FE,
  parameter logic [23:0] DATA_ADDR = 24'h20FF,
  parameter int          NUM_COLS  = 132,
  parameter int          NUM_PAGES = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [23:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  input  logic [3:0]  scan_page,
  input  logic [7:0]  scan_column,
  output logic [7:0]  scan_data,
  output logic [5:0]  start_line,
  output logic [5:0]  contrast,
  output logic        display_on
);

  localparam int         DEPTH    = NUM_COLS * NUM_PAGES;
  localparam int         AW       = $clog2(DEPTH);
  localparam logic [7:0] LAST_COL = 8'(NUM_COLS - 1);

  logic [7:0] mem [DEPTH];  // no reset: contents undefined after reset

  logic [7:0] column;
  logic [3:0] page;
  logic       adc, invert, all_on, contrast_pending;
  logic [7:0] read_latch;
  logic       rmw;
`ifdef LCD_RMW_EN
  logic [7:0] rmw_column;
`else
  assign rmw = 1'b0;
`endif

  function automatic logic [AW-1:0] ram_idx(input logic [3:0] p, input logic [7:0] c);
    return AW'(p) * AW'(NUM_COLS) + AW'(c);
  endfunction

  // Bus decode; a simultaneous write suppresses the read.
  logic cmd_wr, data_wr, data_rd;
  assign cmd_wr  = bus_write && (bus_address_in == CMD_ADDR);
  assign data_wr = bus_write && (bus_address_in == DATA_ADDR);
  assign data_rd = bus_read && !bus_write && (bus_address_in == DATA_ADDR);

  logic          bus_ok;
  logic [AW-1:0] bus_idx;
  logic [7:0]    col_next;
  assign bus_ok   = (int'(page) < NUM_PAGES) && (int'(column) < NUM_COLS);
  assign bus_idx  = ram_idx(page, column);
  // Column auto-increment stops at the last column (also holds anything beyond).
  assign col_next = (column >= LAST_COL) ? column : column + 8'd1;

  // Bus-side write port.
  always_ff @(posedge clk) begin
    if (data_wr && bus_ok) mem[bus_idx] <= bus_data_in;
  end

  // Scanout side: ADC mirrors the column, then all_on / invert / display_on
  // are applied in that order. Non-blocking RAM semantics make a same-cycle
  // bus write to the scanned byte return the old data.
  logic          scan_ok;
  logic [7:0]    phys_col, scan_next;
  logic [AW-1:0] scan_idx;
  assign scan_ok  = (int'(scan_page) < NUM_PAGES) && (int'(scan_column) < NUM_COLS);
  assign phys_col = adc ? (LAST_COL - scan_column) : scan_column;
  assign scan_idx = ram_idx(scan_page, phys_col);

  always_comb begin
    scan_next = mem[scan_idx];
    if (all_on) scan_next = 8'hFF;
    if (invert) scan_next = ~scan_next;
    if (!display_on || !scan_ok) scan_next = 8'h00;
  end

  // Status reports busy=0, ADC, and display OFF (inverted enable).
  always_comb begin
    bus_data_out = 8'h00;
    if (bus_address_in == CMD_ADDR)       bus_data_out = {1'b0, adc, ~display_on, 5'b0};
    else if (bus_address_in == DATA_ADDR) bus_data_out = read_latch;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      column           <= '0;
      page             <= '0;
      start_line       <= '0;
      adc              <= 1'b0;
      invert           <= 1'b0;
      all_on           <= 1'b0;
      display_on       <= 1'b0;
      contrast         <= 6'h20;
      contrast_pending <= 1'b0;
      read_latch       <= '0;
      scan_data        <= '0;
`ifdef LCD_RMW_EN
      rmw              <= 1'b0;
      rmw_column       <= '0;
`endif
    end else begin
      scan_data <= scan_next;
      if (cmd_wr) begin
        // The byte after 0x81 is the contrast operand, not an opcode.
        if (contrast_pending) begin
          contrast         <= bus_data_in[5:0];
          contrast_pending <= 1'b0;
        end else begin
          case (bus_data_in) inside
            [8'h00:8'h0F]: column[3:0] <= bus_data_in[3:0];
            [8'h10:8'h1F]: column[7:4] <= bus_data_in[3:0];
            [8'h40:8'h7F]: start_line  <= bus_data_in[5:0];
            8'h81:         contrast_pending <= 1'b1;
            8'hA0, 8'hA1:  adc        <= bus_data_in[0];
            8'hA4, 8'hA5:  all_on     <= bus_data_in[0];
            8'hA6, 8'hA7:  invert     <= bus_data_in[0];
            8'hAE, 8'hAF:  display_on <= bus_data_in[0];
            [8'hB0:8'hBF]: page       <= bus_data_in[3:0];
`ifdef LCD_RMW_EN
            8'hE0: begin
              rmw        <= 1'b1;
              rmw_column <= column;
            end
            8'hEE: begin
              rmw    <= 1'b0;
              column <= rmw_column;
            end
`endif
            // Software reset keeps display_on and RAM contents.
            8'hE2: begin
              column           <= '0;
              page             <= '0;
              start_line       <= '0;
              adc              <= 1'b0;
              invert           <= 1'b0;
              all_on           <= 1'b0;
              contrast         <= 6'h20;
              contrast_pending <= 1'b0;
`ifdef LCD_RMW_EN
              rmw              <= 1'b0;
`endif
            end
            default: ;
          endcase
        end
      end else if (data_wr) begin
        column <= col_next;
      end else if (data_rd) begin
        // Dummy-read pipeline: this strobe returned the old latch and
        // fetches the current address for the next read.
        read_latch <= bus_ok ? mem[bus_idx] : 8'h00;
        if (!rmw) column <= col_next;
      end
    end
  end

endmodule

// File: tb/tb_lcd_sed1565.sv
// tb_lcd_sed1565 -- self-checking bench for lcd_sed1565: reset-during-write,
// a table of directed vectors, hand sequences for software reset, scanout
// write collision, write/read collision and read-modify-write, then random
// traffic checked against a behavioural model.
module tb_lcd_sed1565;
  localparam logic [23:0] CMD = 24'h20FE;
  localparam logic [23:0] DAT = 24'h20FF;

  logic        clk = 1'b0, reset_n = 1'b0, bus_write = 1'b0, bus_read = 1'b0;
  logic [23:0] bus_address_in = '0;
  logic [7:0]  bus_data_in = '0;
  logic [7:0]  bus_data_out, scan_data;
  logic [3:0]  scan_page = '0;
  logic [7:0]  scan_column = '0;
  logic [5:0]  start_line, contrast;
  logic        display_on;

  int checks = 0;
  int errors = 0;

  lcd_sed1565 dut (
    .clk(clk), .reset_n(reset_n), .bus_write(bus_write), .bus_read(bus_read),
    .bus_address_in(bus_address_in), .bus_data_in(bus_data_in),
    .bus_data_out(bus_data_out), .scan_page(scan_page), .scan_column(scan_column),
    .scan_data(scan_data), .start_line(start_line), .contrast(contrast),
    .display_on(display_on)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  // ---- bus tasks: each starts and ends 1 time unit after a rising edge ----
  task automatic cmd(input logic [7:0] d);
    bus_address_in = CMD; bus_data_in = d; bus_write = 1'b1;
    @(posedge clk); #1 bus_write = 1'b0;
  endtask

  task automatic dwr(input logic [7:0] d);
    bus_address_in = DAT; bus_data_in = d; bus_write = 1'b1;
    @(posedge clk); #1 bus_write = 1'b0;
  endtask

  task automatic wrrd(input logic [7:0] d);
    bus_address_in = DAT; bus_data_in = d; bus_write = 1'b1; bus_read = 1'b1;
    @(posedge clk); #1 bus_write = 1'b0; bus_read = 1'b0;
  endtask

  task automatic drd(output logic [7:0] got);
    bus_address_in = DAT; bus_read = 1'b1;
    #2 got = bus_data_out;
    @(posedge clk); #1 bus_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic stat(output logic [7:0] got);
    bus_address_in = CMD; bus_read = 1'b1;
    #2 got = bus_data_out;
    @(posedge clk); #1 bus_read = 1'b0;
  endtask

  task automatic scan(input logic [3:0] p, input logic [7:0] c, output logic [7:0] got);
    scan_page = p; scan_column = c;
    @(posedge clk); #1 got = scan_data;
  endtask

  // ---- behavioural model ----
`ifdef LCD_RMW_EN
  localparam bit HAS_RMW = 1'b1;
`else
  localparam bit HAS_RMW = 1'b0;
`endif
  logic [7:0] mram [9][132];
  int         m_col, m_page, m_sl, m_con, m_rmwcol;
  bit         m_adc, m_inv, m_all, m_don, m_pend, m_rmw;
  logic [7:0] m_latch;

  function automatic void m_soft();
    m_col = 0; m_page = 0; m_sl = 0; m_adc = 0; m_inv = 0; m_all = 0;
    m_con = 32; m_pend = 0; m_rmw = 0;
  endfunction

  function automatic void m_hard();
    m_soft(); m_don = 0; m_latch = 8'h00; m_rmwcol = 0;
  endfunction

  function automatic void m_cmd(input int d);
    if (m_pend) begin m_con = d % 64; m_pend = 0; end
    else if (d < 16)                 m_col = (m_col / 16) * 16 + d;
    else if (d < 32)                 m_col = (d - 16) * 16 + m_col % 16;
    else if (d >= 64 && d < 128)     m_sl = d - 64;
    else if (d == 'h81)              m_pend = 1;
    else if (d == 'hA0 || d == 'hA1) m_adc = d[0];
    else if (d == 'hA4 || d == 'hA5) m_all = d[0];
    else if (d == 'hA6 || d == 'hA7) m_inv = d[0];
    else if (d == 'hAE || d == 'hAF) m_don = d[0];
    else if (d >= 'hB0 && d <= 'hBF) m_page = d - 'hB0;
    else if (d == 'hE0 && HAS_RMW) begin m_rmw = 1; m_rmwcol = m_col; end
    else if (d == 'hEE && HAS_RMW) begin m_rmw = 0; m_col = m_rmwcol; end
    else if (d == 'hE2)              m_soft();
  endfunction

  function automatic void m_dw(input logic [7:0] d);
    if (m_page < 9 && m_col < 132) mram[m_page][m_col] = d;
    if (m_col < 131) m_col++;
  endfunction

  function automatic logic [7:0] m_rd();
    logic [7:0] r = m_latch;
    m_latch = (m_page < 9 && m_col < 132) ? mram[m_page][m_col] : 8'h00;
    if (!m_rmw && m_col < 131) m_col++;
    return r;
  endfunction

  function automatic logic [7:0] m_scan(input int p, input int c);
    logic [7:0] b;
    if (p > 8 || c > 131 || !m_don) return 8'h00;
    b = mram[p][m_adc ? 131 - c : c];
    if (m_all) b = 8'hFF;
    if (m_inv) b = ~b;
    return b;
  endfunction

  // ---- directed vector table ----
  typedef enum int {OP_CMD, OP_DW, OP_RD, OP_ST, OP_SC, OP_CON, OP_SL} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] d;
    logic [3:0] sp;
    logic [7:0] sc;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void vp(input op_e op, input logic [7:0] d, input logic [3:0] sp,
                             input logic [7:0] sc, input logic [7:0] exp);
    vec_t v;
    v.op = op; v.d = d; v.sp = sp; v.sc = sc; v.exp = exp;
    tbl.push_back(v);
  endfunction
  function automatic void vc(input logic [7:0] d);   vp(OP_CMD, d, 0, 0, 0);   endfunction
  function automatic void vw(input logic [7:0] d);   vp(OP_DW, d, 0, 0, 0);    endfunction
  function automatic void vr(input logic [7:0] e);   vp(OP_RD, 0, 0, 0, e);    endfunction
  function automatic void vst(input logic [7:0] e);  vp(OP_ST, 0, 0, 0, e);    endfunction
  function automatic void vk(input logic [7:0] e);   vp(OP_CON, 0, 0, 0, e);   endfunction
  function automatic void vl(input logic [7:0] e);   vp(OP_SL, 0, 0, 0, e);    endfunction
  function automatic void vs(input logic [3:0] p, input logic [7:0] c, input logic [7:0] e);
    vp(OP_SC, 0, p, c, e);
  endfunction

  function automatic void build_table();
    vst(8'h20); vk(8'h20);
    // write path: page 3, column 0x25
    vc(8'hB3); vc(8'h12); vc(8'h05); vw(8'hA5); vw(8'h3C); vw(8'h5A); vc(8'hAF);
    vs(3, 8'h25, 8'hA5); vs(3, 8'h26, 8'h3C); vst(8'h00);
    // read path with dummy read
    vc(8'hB3); vc(8'h12); vc(8'h05); vr(8'h00); vr(8'hA5); vr(8'h3C);
    // saturation at column 131 on page 8
    vc(8'hB8); vc(8'h18); vc(8'h03); vw(8'h11); vw(8'h22);
    vs(8, 8'd131, 8'h22); vr(8'h5A); vr(8'h22);
    // page 9 is out of range
    vc(8'hB9); vc(8'h00); vc(8'h10); vw(8'h99); vr(8'h22); vr(8'h00);
    vs(9, 8'd0, 8'h00); vs(8, 8'd132, 8'h00);
    // contrast operand and start line
    vc(8'h81); vc(8'h3F); vk(8'h3F); vst(8'h00); vl(8'h00); vc(8'h4A); vl(8'h0A);
    // ADC mirror, invert, all-on, display off
    vc(8'hA1); vs(8, 8'd0, 8'h22); vst(8'h40); vs(3, 8'h5E, 8'hA5);
    vc(8'hA7); vs(8, 8'd0, 8'hDD); vs(3, 8'h5E, 8'h5A);
    vc(8'hA5); vs(8, 8'd0, 8'h00); vc(8'hA4); vs(8, 8'd0, 8'hDD);
    vc(8'hAE); vs(8, 8'd0, 8'h00); vst(8'h60);
  endfunction

  // ---- random traffic against the model ----
  task automatic rnd_cmd();
    logic [7:0] d;
    case ($urandom_range(0, 11))
      0:  d = 8'($urandom_range(0, 15));
      1:  d = 8'(16 + $urandom_range(0, 8));
      2:  d = 8'(8'h40 + $urandom_range(0, 63));
      3:  begin cmd(8'h81); m_cmd('h81); d = 8'($urandom_range(0, 255)); end
      4:  d = 8'(8'hA0 + $urandom_range(0, 1));
      5:  d = 8'(8'hA4 + $urandom_range(0, 1));
      6:  d = 8'(8'hA6 + $urandom_range(0, 1));
      7:  d = ($urandom_range(0, 3) == 0) ? 8'hAE : 8'hAF;
      8:  d = 8'(8'hB0 + $urandom_range(0, 9));
      9:  d = $urandom_range(0, 1) ? 8'hE0 : 8'hEE;
      10: d = ($urandom_range(0, 3) == 0) ? 8'hE2 : 8'hE3;
      default: d = 8'($urandom_range(0, 255));
    endcase
    cmd(d); m_cmd(int'(d));
  endtask

  initial begin
    logic [7:0] got;
    // ---- reset, then reset asserted in the middle of a write ----
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_contrast", {2'b0, contrast}, 8'h20);
    chk("rst_display_on", {7'b0, display_on}, 8'h00);
    cmd(8'hAF); cmd(8'h81); cmd(8'h10);
    chk("pre_contrast", {2'b0, contrast}, 8'h10);
    chk("pre_display_on", {7'b0, display_on}, 8'h01);
    bus_address_in = CMD; bus_data_in = 8'hA1; bus_write = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_contrast", {2'b0, contrast}, 8'h20);
    chk("midrst_display_on", {7'b0, display_on}, 8'h00);
    chk("midrst_status", bus_data_out, 8'h20);
    chk("midrst_scan", scan_data, 8'h00);
    @(posedge clk); #1;
    chk("rst_held_status", bus_data_out, 8'h20);
    bus_write = 1'b0; reset_n = 1'b1;

    // ---- directed table ----
    build_table();
    for (int i = 0; i < tbl.size(); i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      case (tbl[i].op)
        OP_CMD: cmd(tbl[i].d);
        OP_DW:  dwr(tbl[i].d);
        OP_RD:  begin drd(got); chk(nm, got, tbl[i].exp); end
        OP_ST:  begin stat(got); chk(nm, got, tbl[i].exp); end
        OP_SC:  begin scan(tbl[i].sp, tbl[i].sc, got); chk(nm, got, tbl[i].exp); end
        OP_CON: chk(nm, {2'b0, contrast}, tbl[i].exp);
        OP_SL:  chk(nm, {2'b0, start_line}, tbl[i].exp);
        default: ;
      endcase
    end

    // ---- software reset keeps display_on and RAM ----
    cmd(8'hAF); cmd(8'hE2);
    chk("e2_contrast", {2'b0, contrast}, 8'h20);
    chk("e2_start_line", {2'b0, start_line}, 8'h00);
    chk("e2_display_on", {7'b0, display_on}, 8'h01);
    stat(got); chk("e2_status", got, 8'h00);
    scan(3, 8'h25, got); chk("e2_ram_kept", got, 8'hA5);
    dwr(8'h66);
    scan(0, 8'h00, got); chk("e2_addr_home", got, 8'h66);

    // ---- same-cycle bus write to the scanned byte returns old data ----
    cmd(8'hB3); cmd(8'h12); cmd(8'h05);
    scan_page = 4'd3; scan_column = 8'h25;
    dwr(8'h77);
    chk("collide_old", scan_data, 8'hA5);
    @(posedge clk); #1;
    chk("collide_new", scan_data, 8'h77);

    // ---- write and read together: write lands, read ignored ----
    wrrd(8'h44);

    // ---- read-modify-write ----
    cmd(8'hB3); cmd(8'h12); cmd(8'h05); cmd(8'hE0);
    drd(got); chk("rmw_r1", got, 8'h00);
    drd(got); chk("rmw_r2", got, 8'h77);
`ifdef LCD_RMW_EN
    dwr(8'h88); cmd(8'hEE);
    drd(got); chk("rmw_r3", got, 8'h77);
    drd(got); chk("rmw_r4", got, 8'h88);
    scan(3, 8'h26, got); chk("rmw_neighbour", got, 8'h44);
`else
    drd(got); chk("normw_r3", got, 8'h44);
`endif

    // ---- random traffic vs model ----
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    m_hard();
    for (int p = 0; p < 9; p++) begin
      cmd(8'(8'hB0 + p)); m_cmd('hB0 + p);
      cmd(8'h00); m_cmd(0);
      cmd(8'h10); m_cmd('h10);
      for (int c = 0; c < 132; c++) begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        dwr(b); m_dw(b);
      end
    end
    cmd(8'hAF); m_cmd('hAF);
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 30) rnd_cmd();
      else if (r < 55) begin
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        dwr(b); m_dw(b);
      end else if (r < 70) begin
        drd(got); chk($sformatf("rnd%0d_read", n), got, m_rd());
      end else if (r < 90) begin
        int p, c;
        p = $urandom_range(0, 10); c = $urandom_range(0, 140);
        scan(4'(p), 8'(c), got); chk($sformatf("rnd%0d_scan", n), got, m_scan(p, c));
      end else begin
        stat(got); chk($sformatf("rnd%0d_status", n), got, {1'b0, m_adc, ~m_don, 5'b0});
      end
      chk($sformatf("rnd%0d_outs", n), {display_on, 1'b0, contrast}, {m_don, 1'b0, 6'(m_con)});
      chk($sformatf("rnd%0d_sl", n), {2'b0, start_line}, 8'(m_sl));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
